// File: rtl/updown_mod_counter.sv
// updown_mod_counter: synchronous up/down counter with programmable modulus,
// parallel load, cascade tc and wrap pulse; UPDOWN_MOD_COUNTER_GRAY_EN adds gray.
module updown_mod_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             up_down,
    input  logic [WIDTH-1:0] modulus,
    output logic [WIDTH-1:0] count,
    output logic             tc,
`ifdef UPDOWN_MOD_COUNTER_GRAY_EN
    output logic             wrap,
    output logic [WIDTH-1:0] gray
`else
    output logic             wrap
`endif
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic [WIDTH-1:0] w_top;
    logic [WIDTH-1:0] w_next;
    logic             w_zero;
    logic             w_over;
    logic             w_up_wrap;
    logic             w_dn_wrap;
    logic             w_step_wrap;

    // Highest legal count; modulus 0 means the full binary range.
    always_comb begin
        w_top = (modulus == '0) ? '1 : (modulus - ONE);
    end

    // Wrap conditions; a count above top (modulus lowered) wraps to 0 either way.
    always_comb begin
        w_zero      = (r_count == '0);
        w_over      = (r_count > w_top);
        w_up_wrap   = (r_count >= w_top);
        w_dn_wrap   = w_zero | w_over;
        w_step_wrap = up_down ? w_up_wrap : w_dn_wrap;
        tc          = enable & ~load & w_step_wrap;
    end

    // Next count: load (clamped to top) beats enable beats hold.
    always_comb begin
        w_next = r_count;
        if (load) begin
            w_next = (load_value > w_top) ? w_top : load_value;
        end else if (enable) begin
            if (up_down) begin
                w_next = w_up_wrap ? '0 : (r_count + ONE);
            end else if (w_zero) begin
                w_next = w_top;
            end else if (w_over) begin
                w_next = '0;
            end else begin
                w_next = r_count - ONE;
            end
        end
    end

    // Count and one-cycle wrap pulse registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_count <= w_next;
            r_wrap  <= tc;
        end
    end

    assign count = r_count;
    assign wrap  = r_wrap;

`ifdef UPDOWN_MOD_COUNTER_GRAY_EN
    logic [WIDTH-1:0] r_gray;

    // Gray code of the next count, updated on the same edge as count.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_gray <= '0;
        end else begin
            r_gray <= w_next ^ (w_next >> 1);
        end
    end

    assign gray = r_gray;
`endif

endmodule

// File: tb/tb_updown_mod_counter.sv
// tb_updown_mod_counter: directed bench for updown_mod_counter (WIDTH=4),
// including a two-digit decimal cascade.
module tb_updown_mod_counter;

    logic       clock;
    logic       reset_n;
    logic       enable;
    logic       load;
    logic [3:0] load_value;
    logic       up_down;
    logic [3:0] modulus;
    logic [3:0] lo_count;
    logic       lo_tc;
    logic       lo_wrap;
    logic [3:0] hi_count;
    logic       hi_tc;
    logic       hi_wrap;
`ifdef UPDOWN_MOD_COUNTER_GRAY_EN
    logic [3:0] lo_gray;
    logic [3:0] hi_gray;
`endif

    int n_cmp;
    int n_err;

    updown_mod_counter #(.WIDTH(4)) u_lo (
        .clock      (clock),
        .reset_n    (reset_n),
        .enable     (enable),
        .load       (load),
        .load_value (load_value),
        .up_down    (up_down),
        .modulus    (modulus),
        .count      (lo_count),
        .tc         (lo_tc),
`ifdef UPDOWN_MOD_COUNTER_GRAY_EN
        .wrap       (lo_wrap),
        .gray       (lo_gray)
`else
        .wrap       (lo_wrap)
`endif
    );

    updown_mod_counter #(.WIDTH(4)) u_hi (
        .clock      (clock),
        .reset_n    (reset_n),
        .enable     (lo_tc),
        .load       (1'b0),
        .load_value (4'd0),
        .up_down    (up_down),
        .modulus    (modulus),
        .count      (hi_count),
        .tc         (hi_tc),
`ifdef UPDOWN_MOD_COUNTER_GRAY_EN
        .wrap       (hi_wrap),
        .gray       (hi_gray)
`else
        .wrap       (hi_wrap)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [3:0] g(input logic [3:0] c);
        return c ^ (c >> 1);
    endfunction

    task automatic chk_gray(input logic [3:0] exp_lo, input logic [3:0] exp_hi);
`ifdef UPDOWN_MOD_COUNTER_GRAY_EN
        chk("gray_lo", 32'(lo_gray), 32'(g(exp_lo)));
        chk("gray_hi", 32'(hi_gray), 32'(g(exp_hi)));
`else
        if (exp_lo == exp_hi) begin end
`endif
    endtask

    initial begin
        logic [3:0] e;
        logic [3:0] e_lo;
        logic [3:0] e_hi;
        logic       t_lo;
        logic       t_hi;
        n_cmp = 0;
        n_err = 0;

        reset_n    = 1'b0;
        enable     = 1'b0;
        load       = 1'b0;
        load_value = 4'd0;
        up_down    = 1'b1;
        modulus    = 4'd0;
        #12;
        chk("rst_count", 32'(lo_count), 0);
        chk("rst_wrap", 32'(lo_wrap), 0);
        chk("rst_tc", 32'(lo_tc), 0);
`ifdef UPDOWN_MOD_COUNTER_GRAY_EN
        chk("rst_gray", 32'(lo_gray), 0);
`endif

        // Full-range up count for 17 edges.
        reset_n = 1'b1;
        enable  = 1'b1;
        #1;
        chk("full_tc0", 32'(lo_tc), 0);
        for (int i = 1; i <= 17; i++) begin
            tick();
            e = 4'(i % 16);
            chk("full_count", 32'(lo_count), 32'(e));
            chk("full_wrap", 32'(lo_wrap), (i == 16) ? 1 : 0);
            chk("full_tc", 32'(lo_tc), (e == 4'd15) ? 1 : 0);
`ifdef UPDOWN_MOD_COUNTER_GRAY_EN
            chk("full_gray", 32'(lo_gray), 32'(g(e)));
`endif
        end

        // Asynchronous reset mid-count at 9.
        load       = 1'b1;
        load_value = 4'd9;
        tick();
        chk("ld9_count", 32'(lo_count), 9);
        chk("ld9_wrap", 32'(lo_wrap), 0);
        load = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_count", 32'(lo_count), 0);
        chk("async_wrap", 32'(lo_wrap), 0);
        #1;
        reset_n = 1'b1;
        tick();
        chk("resume_count", 32'(lo_count), 1);

        // Mod-10 down from 2.
        modulus    = 4'd10;
        up_down    = 1'b0;
        load       = 1'b1;
        load_value = 4'd2;
        tick();
        chk("d_ld_count", 32'(lo_count), 2);
        load = 1'b0;
        tick();
        chk("d_count1", 32'(lo_count), 1);
        chk("d_tc1", 32'(lo_tc), 0);
        tick();
        chk("d_count0", 32'(lo_count), 0);
        chk("d_tc0", 32'(lo_tc), 1);
        chk("d_wrap0", 32'(lo_wrap), 0);
        tick();
        chk("d_count9", 32'(lo_count), 9);
        chk("d_wrap9", 32'(lo_wrap), 1);
        chk("d_tc9", 32'(lo_tc), 0);
        tick();
        chk("d_count8", 32'(lo_count), 8);
        chk("d_wrap8", 32'(lo_wrap), 0);

        // Load priority and clamp at count 9 (about to wrap up).
        up_down = 1'b1;
        tick();
        chk("p_count9", 32'(lo_count), 9);
        #1;
        chk("p_tc_pre", 32'(lo_tc), 1);
        load       = 1'b1;
        load_value = 4'd13;
        #1;
        chk("p_tc_load", 32'(lo_tc), 0);
        tick();
        chk("p_clamp", 32'(lo_count), 9);
        chk("p_wrap", 32'(lo_wrap), 0);
`ifdef UPDOWN_MOD_COUNTER_GRAY_EN
        chk("p_gray", 32'(lo_gray), 32'(g(4'd9)));
`endif

        // Modulus lowered mid-run, up direction.
        load_value = 4'd8;
        enable     = 1'b0;
        tick();
        chk("m_ld8", 32'(lo_count), 8);
        load    = 1'b0;
        enable  = 1'b1;
        modulus = 4'd5;
        #1;
        chk("m_up_tc", 32'(lo_tc), 1);
        tick();
        chk("m_up_count", 32'(lo_count), 0);
        chk("m_up_wrap", 32'(lo_wrap), 1);

        // Modulus lowered mid-run, down direction.
        modulus    = 4'd10;
        load       = 1'b1;
        load_value = 4'd8;
        tick();
        chk("m_ld8b", 32'(lo_count), 8);
        chk("m_ld_wrap", 32'(lo_wrap), 0);
        load    = 1'b0;
        modulus = 4'd5;
        up_down = 1'b0;
        #1;
        chk("m_dn_tc", 32'(lo_tc), 1);
        tick();
        chk("m_dn_count", 32'(lo_count), 0);
        chk("m_dn_wrap", 32'(lo_wrap), 1);

        // Modulus 1: top is 0, every step wraps.
        modulus = 4'd1;
        up_down = 1'b1;
        tick();
        chk("m1_count", 32'(lo_count), 0);
        chk("m1_wrap", 32'(lo_wrap), 1);
        chk("m1_tc", 32'(lo_tc), 1);
        up_down = 1'b0;
        #1;
        chk("m1_tc_dn", 32'(lo_tc), 1);
        tick();
        chk("m1_count_dn", 32'(lo_count), 0);
        chk("m1_wrap_dn", 32'(lo_wrap), 1);

        // Two-digit decimal cascade 00..99..00.
        reset_n = 1'b0;
        #1;
        modulus = 4'd10;
        up_down = 1'b1;
        enable  = 1'b1;
        load    = 1'b0;
        #1;
        reset_n = 1'b1;
        chk("c_lo0", 32'(lo_count), 0);
        chk("c_hi0", 32'(hi_count), 0);
        e_lo = 4'd0;
        e_hi = 4'd0;
        for (int i = 1; i <= 100; i++) begin
            t_lo = (e_lo == 4'd9);
            t_hi = t_lo && (e_hi == 4'd9);
            chk("c_lo_tc", 32'(lo_tc), 32'(t_lo));
            chk("c_hi_tc", 32'(hi_tc), 32'(t_hi));
            tick();
            if (t_lo) begin
                e_lo = 4'd0;
                e_hi = (e_hi == 4'd9) ? 4'd0 : e_hi + 4'd1;
            end else begin
                e_lo = e_lo + 4'd1;
            end
            chk("c_lo", 32'(lo_count), 32'(e_lo));
            chk("c_hi", 32'(hi_count), 32'(e_hi));
            chk("c_hi_wrap", 32'(hi_wrap), 32'(t_hi));
            chk_gray(e_lo, e_hi);
        end
        chk("c_end_lo", 32'(lo_count), 0);
        chk("c_end_hi", 32'(hi_count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
